// File: rtl/lc3_program_loader.sv
// Framed byte-stream loader for the LC-3 direct memory port: packs big-endian words,
// writes them from the frame origin, and holds the CPU in reset until the checksum verifies.
module lc3_program_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         TIMEOUT_W      = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        arm,
    output logic [15:0] address_in_direct,
    output logic [15:0] data_in_direct,
    output logic        mem_we,
    output logic        cpu_hold,
    output logic        done,
    output logic [1:0]  error_code,
    output logic [15:0] start_pc
);

    typedef enum logic [3:0] {
        S_SYNC, S_ORIG_HI, S_ORIG_LO, S_CNT_HI, S_CNT_LO,
        S_DATA_HI, S_DATA_LO, S_WRITE, S_CHK, S_DONE, S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CHKSUM  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [TIMEOUT_W-1:0] IDLE_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [15:0]          addr_q, addr_d;
    logic [15:0]          orig_q, orig_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          data_q, data_d;
    logic [7:0]           sum_q, sum_d;
    logic [TIMEOUT_W-1:0] idle_q, idle_d;
    logic [1:0]           err_q, err_d;
    logic [15:0]          start_pc_q, start_pc_d;
    logic                 rx_ready_q, rx_ready_d;
    logic                 mem_we_q, mem_we_d;
    logic                 cpu_hold_q, cpu_hold_d;
    logic                 done_q, done_d;

    logic       accept;
    logic       counting;
    logic       timeout;
    logic [7:0] sum_plus_rx;

    assign accept      = rx_valid && rx_ready_q;
    assign sum_plus_rx = sum_q + rx_data;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        orig_d     = orig_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        sum_d      = sum_q;
        err_d      = err_q;
        start_pc_d = start_pc_q;

        counting = !(state_q inside {S_SYNC, S_WRITE, S_DONE, S_ERROR});
        idle_d   = (counting && !accept) ? idle_q + TIMEOUT_W'(1) : '0;
        timeout  = counting && !accept && (idle_q == IDLE_LAST);

        unique case (state_q)
            S_SYNC: if (accept && rx_data == SYNC_BYTE) begin
                state_d = S_ORIG_HI;
                sum_d   = 8'h00;
            end
            S_ORIG_HI: if (accept) begin
                addr_d[15:8] = rx_data;
                orig_d[15:8] = rx_data;
                sum_d        = sum_plus_rx;
                state_d      = S_ORIG_LO;
            end
            S_ORIG_LO: if (accept) begin
                addr_d[7:0] = rx_data;
                orig_d[7:0] = rx_data;
                sum_d       = sum_plus_rx;
                state_d     = S_CNT_HI;
            end
            S_CNT_HI: if (accept) begin
                cnt_d[15:8] = rx_data;
                sum_d       = sum_plus_rx;
                state_d     = S_CNT_LO;
            end
            S_CNT_LO: if (accept) begin
                cnt_d[7:0] = rx_data;
                sum_d      = sum_plus_rx;
                state_d    = ({cnt_q[15:8], rx_data} == 16'h0000) ? S_CHK : S_DATA_HI;
            end
            S_DATA_HI: if (accept) begin
                data_d[15:8] = rx_data;
                sum_d        = sum_plus_rx;
                state_d      = S_DATA_LO;
            end
            S_DATA_LO: if (accept) begin
                data_d[7:0] = rx_data;
                sum_d       = sum_plus_rx;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                // The write strobe is high in this cycle; the pointer moves on only afterwards.
                addr_d  = addr_q + 16'd1;
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? S_CHK : S_DATA_HI;
            end
            S_CHK: if (accept) begin
                if (sum_plus_rx == 8'h00) begin
                    state_d    = S_DONE;
                    start_pc_d = orig_q;
                end else begin
                    state_d = S_ERROR;
                    err_d   = ERR_CHKSUM;
                end
            end
            S_DONE, S_ERROR: if (arm) begin
                state_d = S_SYNC;
                err_d   = ERR_NONE;
            end
            default: state_d = S_SYNC;
        endcase

        if (timeout) begin
            state_d = S_ERROR;
            err_d   = ERR_TIMEOUT;
        end

        // Outputs are decoded from the next state so they are registered yet aligned with it.
        rx_ready_d = !(state_d inside {S_WRITE, S_DONE, S_ERROR});
        mem_we_d   = (state_d == S_WRITE);
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_SYNC;
            addr_q     <= '0;
            orig_q     <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            sum_q      <= '0;
            idle_q     <= '0;
            err_q      <= ERR_NONE;
            start_pc_q <= '0;
            rx_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            orig_q     <= orig_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            sum_q      <= sum_d;
            idle_q     <= idle_d;
            err_q      <= err_d;
            start_pc_q <= start_pc_d;
            rx_ready_q <= rx_ready_d;
            mem_we_q   <= mem_we_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
        end
    end

    assign rx_ready          = rx_ready_q;
    assign address_in_direct = addr_q;
    assign data_in_direct    = data_q;
    assign mem_we            = mem_we_q;
    assign cpu_hold          = cpu_hold_q;
    assign done              = done_q;
    assign error_code        = err_q;
    assign start_pc          = start_pc_q;

endmodule

// File: tb/tb_lc3_program_loader.sv
// Directed bench for lc3_program_loader: good, noisy, empty, bad-checksum, timeout and
// mid-frame-reset frames, checked with immediate assertions against hand-computed values.
module tb_lc3_program_loader;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        arm;
    logic [15:0] address_in_direct;
    logic [15:0] data_in_direct;
    logic        mem_we;
    logic        cpu_hold;
    logic        done;
    logic [1:0]  error_code;
    logic [15:0] start_pc;

    int n_checks = 0;
    int n_fails  = 0;

    word_q_t wr_log;
    logic    prev_we = 1'b0;
    int      long_pulses = 0;

    always #5 clk = ~clk;

    lc3_program_loader #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_W      (5)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .arm               (arm),
        .address_in_direct (address_in_direct),
        .data_in_direct    (data_in_direct),
        .mem_we            (mem_we),
        .cpu_hold          (cpu_hold),
        .done              (done),
        .error_code        (error_code),
        .start_pc          (start_pc)
    );

    // Record every write strobe and flag any strobe lasting more than one cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_log.push_back({address_in_direct, data_in_direct});
            if (prev_we) long_pulses++;
        end
        prev_we = (mem_we === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (rx_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1 rx_valid = 1'b0;
        if (!ok) check("rx_ready_wait", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input byte_q_t fr);
        foreach (fr[i]) send_byte(fr[i]);
    endtask

    task automatic wait_end();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1 || (error_code !== 2'b00 && error_code !== 2'bxx)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("end_wait", 32'd0, 32'd1);
    endtask

    task automatic check_writes(input string tag, input word_q_t exp);
        check({tag, "_count"}, 32'(wr_log.size()), 32'(exp.size()));
        foreach (exp[i])
            if (i < wr_log.size()) check($sformatf("%s_w%0d", tag, i), wr_log[i], exp[i]);
        check({tag, "_pulse_len"}, 32'(long_pulses), 32'd0);
    endtask

    task automatic pulse_arm();
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    byte_q_t fr;
    word_q_t exp_w;

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        arm      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done",     32'(done), 32'd0);
        check("rst_err",      32'(error_code), 32'd0);
        check("rst_start_pc", 32'(start_pc), 32'd0);
        check("rst_addr",     32'(address_in_direct), 32'd0);
        check("rst_data",     32'(data_in_direct), 32'd0);
        check("rst_we",       32'(mem_we), 32'd0);
        check("rst_ready",    32'(rx_ready), 32'd0);
        reset = 1'b0;

        // Two-word frame at 0x3000.
        wr_log.delete();
        fr = {8'hA5, 8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hBA};
        send_frame(fr);
        wait_end();
        exp_w = {32'h3000_1234, 32'h3001_5678};
        check_writes("f1", exp_w);
        check("f1_done",     32'(done), 32'd1);
        check("f1_cpu_hold", 32'(cpu_hold), 32'd0);
        check("f1_start_pc", 32'(start_pc), 32'h3000);
        check("f1_err",      32'(error_code), 32'd0);
        check("f1_ready",    32'(rx_ready), 32'd0);

        // Arm keeps start_pc; noise before sync; address wraps past 0xFFFF.
        pulse_arm();
        check("arm_cpu_hold", 32'(cpu_hold), 32'd1);
        check("arm_done",     32'(done), 32'd0);
        check("arm_start_pc", 32'(start_pc), 32'h3000);
        wr_log.delete();
        fr = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02,
              8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hF2};
        send_frame(fr);
        wait_end();
        exp_w = {32'hFFFF_AABB, 32'h0000_CCDD};
        check_writes("wrap", exp_w);
        check("wrap_done",     32'(done), 32'd1);
        check("wrap_start_pc", 32'(start_pc), 32'hFFFF);

        // Empty frame: no writes.
        pulse_arm();
        wr_log.delete();
        fr = {8'hA5, 8'h40, 8'h00, 8'h00, 8'h00, 8'hC0};
        send_frame(fr);
        wait_end();
        exp_w = {};
        check_writes("empty", exp_w);
        check("empty_done",     32'(done), 32'd1);
        check("empty_start_pc", 32'(start_pc), 32'h4000);

        // Bad checksum: writes happen, then error 01.
        pulse_arm();
        wr_log.delete();
        fr = {8'hA5, 8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hBB};
        send_frame(fr);
        wait_end();
        exp_w = {32'h3000_1234, 32'h3001_5678};
        check_writes("bad", exp_w);
        check("bad_err",      32'(error_code), 32'd1);
        check("bad_cpu_hold", 32'(cpu_hold), 32'd1);
        check("bad_done",     32'(done), 32'd0);
        check("bad_ready",    32'(rx_ready), 32'd0);
        pulse_arm();
        check("bad_arm_err", 32'(error_code), 32'd0);
        fr = {8'hA5, 8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hBA};
        send_frame(fr);
        wait_end();
        check("rearm_done", 32'(done), 32'd1);
        check("rearm_err",  32'(error_code), 32'd0);

        // Timeout after 16 idle cycles inside a frame.
        pulse_arm();
        fr = {8'hA5, 8'h30, 8'h00};
        send_frame(fr);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("to_15_err", 32'(error_code), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("to_16_err",      32'(error_code), 32'd2);
        check("to_16_ready",    32'(rx_ready), 32'd0);
        check("to_16_cpu_hold", 32'(cpu_hold), 32'd1);

        // Byte accepted exactly on the 16th idle cycle wins over the timeout.
        pulse_arm();
        fr = {8'hA5, 8'h30, 8'h00};
        send_frame(fr);
        repeat (15) @(posedge clk);
        send_byte(8'h00);
        @(negedge clk);
        check("nto_err", 32'(error_code), 32'd0);
        fr = {8'h00, 8'hD0};
        send_frame(fr);
        wait_end();
        check("nto_done",     32'(done), 32'd1);
        check("nto_start_pc", 32'(start_pc), 32'h3000);

        // Reset after the first data word is written.
        pulse_arm();
        wr_log.delete();
        fr = {8'hA5, 8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34};
        send_frame(fr);
        for (int i = 0; i < 20 && wr_log.size() == 0; i++) @(negedge clk);
        check("mid_first_write", 32'(wr_log.size()), 32'd1);
        pulse_reset();
        check("mid_cpu_hold", 32'(cpu_hold), 32'd1);
        check("mid_done",     32'(done), 32'd0);
        check("mid_ready",    32'(rx_ready), 32'd0);
        check("mid_addr",     32'(address_in_direct), 32'd0);
        repeat (10) @(negedge clk);
        check("mid_no_more_we", 32'(wr_log.size()), 32'd1);
        wr_log.delete();
        fr = {8'hA5, 8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hBA};
        send_frame(fr);
        wait_end();
        exp_w = {32'h3000_1234, 32'h3001_5678};
        check_writes("post_rst", exp_w);
        check("post_rst_done",     32'(done), 32'd1);
        check("post_rst_start_pc", 32'(start_pc), 32'h3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/lc3_program_loader.md
Name: lc3_program_loader

Overview:
Upstream loader for the LC-3 processor's direct memory port. It receives a framed byte stream (UART receiver or testbench), packs it into big-endian 16-bit words, and writes them sequentially from an origin address. It holds the CPU in reset during the load. On a good frame it releases the CPU and reports the origin as the start PC. A bad or stalled frame latches an error.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker; bytes before it are discarded
TIMEOUT_CYCLES, 1000000, max idle cycles between accepted bytes inside a frame
TIMEOUT_W, 20, width of the idle counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock; the single clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader accepts byte; transfer when rx_valid && rx_ready
arm  in  1  one-cycle pulse; restarts loading from DONE/ERROR
address_in_direct  out  16  memory write address
data_in_direct  out  16  memory write data
mem_we  out  1  one-cycle write strobe for the direct port
cpu_hold  out  1  holds the processor in reset while high
done  out  1  frame loaded and verified
error_code  out  2  00 none, 01 checksum mismatch, 10 timeout
start_pc  out  16  origin of the last good frame

Behaviour:
- Frame format: SYNC, ORIG_HI, ORIG_LO, CNT_HI, CNT_LO, then CNT x (DATA_HI, DATA_LO), then CHK.
- Checksum: 8-bit sum of every byte from ORIG_HI through the last data byte, plus CHK, must equal 8'h00 mod 256.
- States: SYNC, ORIG_HI, ORIG_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERROR.
- Reset, which overrides everything including mid-frame: state=SYNC, cpu_hold=1, rx_ready=0 in the reset cycle, mem_we=0, done=0, error_code=00, start_pc=0, address_in_direct=0, data_in_direct=0, running sum=0, idle counter=0.
- rx_ready=1 in SYNC, ORIG_HI, ORIG_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO and CHK. rx_ready=0 in WRITE, DONE and ERROR.
- SYNC: accepted byte == SYNC_BYTE goes to ORIG_HI and clears the sum. Any other byte is dropped.
- ORIG_*: latch the word into the address register. CNT_*: latch the word count.
- After CNT_LO: count==0 goes to CHK; otherwise go to DATA_HI.
- DATA_LO accepted: the next cycle is WRITE.
- WRITE lasts exactly one cycle:
  - mem_we=1, with address_in_direct/data_in_direct stable in that cycle.
  - Then address increments mod 2^16 (16'hFFFF wraps to 16'h0000) and remaining count decrements.
  - Remaining==0 goes to CHK; otherwise go to DATA_HI.
- Latency: mem_we asserts on the cycle after DATA_LO is accepted. One write takes at least 3 cycles.
- CHK: sum+CHK == 0 goes to DONE; otherwise go to ERROR with error_code=01.
- DONE: cpu_hold=0, done=1, start_pc=latched origin. These values hold until arm or reset.
- ERROR: cpu_hold=1, done=0, error_code held. Memory already written is not rolled back.
- arm in DONE/ERROR: next state SYNC, cpu_hold=1, done=0, error_code=00, start_pc retained. arm is ignored in all other states.
- Timeout:
  - The idle counter runs in all states except SYNC, WRITE, DONE and ERROR whenever no byte is accepted.
  - It clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES goes to ERROR with error_code=10.
  - A byte accepted in the same cycle as the timeout wins; the counter clears.
- Bytes arriving while rx_ready=0 are not consumed; the source holds them.
- All outputs are registered.

Test Plan:
- After reset, send A5 30 00 00 02 12 34 56 78 BA -> writes 0x3000<=0x1234, then 0x3001<=0x5678, each mem_we one cycle; then done=1, cpu_hold=0, start_pc=0x3000, error_code=00.
- Noise 00 FF 5A, then A5 FF FF 00 02 AA BB CC DD with valid CHK -> noise is ignored; writes 0xFFFF<=0xAABB, then 0x0000<=0xCCDD (address wrap); then done=1.
- A5 40 00 00 00 C0 -> no mem_we pulses; done=1, start_pc=0x4000.
- First frame with CHK=BB instead of BA -> both writes occur, then error_code=01, cpu_hold=1, done=0. Then pulse arm and send the correct frame -> done=1, error_code=00.
- TIMEOUT_CYCLES=16: A5 30 00, then rx_valid low for 16 cycles -> error_code=10, rx_ready=0. A byte accepted on cycle 16 instead -> no error.
- Assert reset after the first data word is written -> state returns to SYNC, cpu_hold=1, done=0, no further mem_we. A full valid frame then loads correctly.
